// File: rtl/aes_128.sv
// Iterative AES-128 encryptor: one round per clock on a primary datapath, with a
// lockstep redundant datapath that is compared each round. Faults touch the primary only.
module aes_128 (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0][3:0][7:0] data,
  input  logic [3:0][3:0][7:0] key,
  output logic [3:0][3:0][7:0] ciphertext,
  output logic                 done,
  input  logic                 en_FI,
  input  logic                 mode_FI,
  input  logic [3:0]           func_FI,
  input  logic [3:0]           round_FI,
  input  logic [3:0]           round_stop_FI,
  input  logic [1:0]           row_FI,
  input  logic [1:0]           column_FI,
  input  logic [3:0]           bit_index_FI,
  output logic                 error_FI,
  output logic                 fault_detected,
  output logic [3:0]           fault_location
);
  typedef logic [3:0][3:0][7:0] state_t;  // [row][col] byte
  typedef enum logic {S_RUN, S_DONE} fsm_t;

  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TAB[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic state_t sub_bytes(input state_t s);
    state_t o;
    logic [1:0] ri, ci;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        ri = 2'(r);
        ci = 2'(c);
        o[ri][ci] = sbox(s[ri][ci]);
      end
    end
    return o;
  endfunction

  // Row r rotates left by r: out[r][c] = in[r][c+r].
  function automatic state_t shift_rows(input state_t s);
    state_t o;
    logic [1:0] ri, ci;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        ri = 2'(r);
        ci = 2'(c);
        o[ri][ci] = s[ri][ci + ri];
      end
    end
    return o;
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t o;
    logic [1:0] ri, ci;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ri = 2'(r);
        ci = 2'(c);
        o[ri][ci] = xtime(s[ri][ci]) ^ xtime(s[ri + 2'd1][ci]) ^ s[ri + 2'd1][ci]
                  ^ s[ri + 2'd2][ci] ^ s[ri + 2'd3][ci];
      end
    end
    return o;
  endfunction

  // Column c of the state is key word c; derive the next round key from the previous one.
  function automatic state_t next_key(input state_t k, input logic [7:0] rc_in);
    state_t n;
    logic [3:0][7:0] t;
    logic [1:0] ri;
    for (int r = 0; r < 4; r++) begin
      ri = 2'(r);
      t[ri] = sbox(k[ri + 2'd1][2'd3]);
    end
    t[2'd0] = t[2'd0] ^ rc_in;
    for (int r = 0; r < 4; r++) begin
      ri = 2'(r);
      n[ri][2'd0] = k[ri][2'd0] ^ t[ri];
      n[ri][2'd1] = k[ri][2'd1] ^ n[ri][2'd0];
      n[ri][2'd2] = k[ri][2'd2] ^ n[ri][2'd1];
      n[ri][2'd3] = k[ri][2'd3] ^ n[ri][2'd2];
    end
    return n;
  endfunction

  function automatic state_t round_fn(input logic first, input logic last, input state_t s,
                                      input state_t rk, input state_t f_sb, input state_t f_sr,
                                      input state_t f_mc, input state_t f_ark);
    state_t t;
    if (first) begin
      t = s;
    end else begin
      t = sub_bytes(s) ^ f_sb;
      t = shift_rows(t) ^ f_sr;
      if (!last) t = mix_columns(t) ^ f_mc;
    end
    return t ^ rk ^ f_ark;
  endfunction

  fsm_t       fsm, fsm_next;
  logic [3:0] rnd;
  state_t     st_p, st_r, rk_p, rk_r;
  state_t     rk_cur_p, rk_cur_r, out_p, out_r, byte_mask;
  state_t     m_sb, m_sr, m_mc, m_ark, m_key;
  logic       running, in_window, func_ok, inj, first, last;
  logic [7:0] fmask;

  always_comb begin
    fsm_next  = fsm;
    running   = (fsm == S_RUN);
    first     = (rnd == 4'd0);
    last      = (rnd == 4'd10);
    in_window = (rnd == round_FI) ||
                (mode_FI && (rnd >= round_FI) && (rnd <= round_stop_FI));
    case (func_FI)
      4'd0, 4'd1: func_ok = !first;
      4'd2:       func_ok = !first && !last;
      4'd3, 4'd4: func_ok = 1'b1;
      default:    func_ok = 1'b0;
    endcase
    inj       = running && en_FI && in_window && func_ok;
    fmask     = bit_index_FI[3] ? 8'hff : (8'h01 << bit_index_FI[2:0]);
    byte_mask = '0;
    byte_mask[row_FI][column_FI] = fmask;
    m_sb  = (inj && func_FI == 4'd0) ? byte_mask : '0;
    m_sr  = (inj && func_FI == 4'd1) ? byte_mask : '0;
    m_mc  = (inj && func_FI == 4'd2) ? byte_mask : '0;
    m_ark = (inj && func_FI == 4'd3) ? byte_mask : '0;
    m_key = (inj && func_FI == 4'd4) ? byte_mask : '0;
    rk_cur_p = (first ? key : next_key(rk_p, rcon(rnd))) ^ m_key;
    rk_cur_r = first ? key : next_key(rk_r, rcon(rnd));
    out_p = round_fn(first, last, first ? data : st_p, rk_cur_p, m_sb, m_sr, m_mc, m_ark);
    out_r = round_fn(first, last, first ? data : st_r, rk_cur_r, '0, '0, '0, '0);
    if (running && last) fsm_next = S_DONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm            <= S_RUN;
      rnd            <= 4'd0;
      st_p           <= '0;
      st_r           <= '0;
      rk_p           <= '0;
      rk_r           <= '0;
      ciphertext     <= '0;
      done           <= 1'b0;
      error_FI       <= 1'b0;
      fault_detected <= 1'b0;
      fault_location <= 4'd0;
    end else begin
      fsm <= fsm_next;
      if (running) begin
        st_p <= out_p;
        st_r <= out_r;
        rk_p <= rk_cur_p;
        rk_r <= rk_cur_r;
        if (!last) rnd <= rnd + 4'd1;
        if (inj) error_FI <= 1'b1;
        // Only the first mismatching round is recorded.
        if ((out_p != out_r) && !fault_detected) begin
          fault_detected <= 1'b1;
          fault_location <= rnd;
        end
        if (last) begin
          ciphertext <= out_p;
          done       <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_128.sv
// Bench for aes_128: known-answer table with fault scenarios, a mid-run reset
// sequence, and random keys/plaintexts/fault settings against a byte-level AES model.
module tb_aes_128;
  typedef logic [3:0][3:0][7:0] st_t;
  typedef struct packed {
    logic en; logic mode; logic [3:0] func; logic [3:0] rnd; logic [3:0] stop;
    logic [1:0] row; logic [1:0] col; logic [3:0] bitx;
  } fi_t;
  typedef struct packed { logic [127:0] ct; logic err; logic det; logic [3:0] loc; } res_t;
  typedef struct {
    logic [127:0] k; logic [127:0] pt; fi_t f; logic [127:0] ct; logic ct_eq;
    logic err; logic det; logic [3:0] loc;
  } vec_t;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  st_t        data, key, ciphertext;
  logic       done, en_FI, mode_FI, error_FI, fault_detected;
  logic [3:0] func_FI, round_FI, round_stop_FI, bit_index_FI, fault_location;
  logic [1:0] row_FI, column_FI;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]   sb_tab[256];
  logic [127:0] exp_q[$];

  always #5 clock = ~clock;

  aes_128 dut (
    .clock(clock), .reset(reset), .data(data), .key(key), .ciphertext(ciphertext),
    .done(done), .en_FI(en_FI), .mode_FI(mode_FI), .func_FI(func_FI),
    .round_FI(round_FI), .round_stop_FI(round_stop_FI), .row_FI(row_FI),
    .column_FI(column_FI), .bit_index_FI(bit_index_FI), .error_FI(error_FI),
    .fault_detected(fault_detected), .fault_location(fault_location)
  );

  // ---------------- reference model (FIPS byte order: byte i at [127-8i]) ----------------
  function automatic logic [7:0] gb(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0]  inv;
    logic [15:0] d;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      d = {inv, inv};
      sb_tab[x] = inv ^ d[14 -: 8] ^ d[13 -: 8] ^ d[12 -: 8] ^ d[11 -: 8] ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] sub_all(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sb_tab[gb(v, i)];
    return o;
  endfunction

  function automatic logic [127:0] shift(input logic [127:0] v);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[127-8*(r+4*c) -: 8] = gb(v, r + 4*((c + r) % 4));
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] v);
    logic [127:0] o;
    logic [7:0]   a[4];
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = gb(v, 4*c + j);
      for (int j = 0; j < 4; j++)
        o[127-8*(4*c+j) -: 8] = gmul(a[j], 8'h02) ^ gmul(a[(j+1)%4], 8'h03)
                                ^ a[(j+2)%4] ^ a[(j+3)%4];
    end
    return o;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [7:0]   t[4];
    logic [7:0]   nb[16];
    logic [127:0] o;
    for (int j = 0; j < 4; j++) t[j] = sb_tab[gb(k, 12 + (j + 1) % 4)];
    t[0] ^= rc;
    for (int i = 0; i < 4; i++) nb[i] = gb(k, i) ^ t[i];
    for (int i = 4; i < 16; i++) nb[i] = gb(k, i) ^ nb[i-4];
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = nb[i];
    return o;
  endfunction

  function automatic res_t ref_aes(input logic [127:0] pt, input logic [127:0] k, input fi_t f);
    res_t         res;
    logic [127:0] p, q, kp, kq, m;
    logic [7:0]   rc;
    logic         hit;
    int           idx;
    res = '0;
    rc  = 8'h01;
    idx = int'(f.row) + 4 * int'(f.col);
    m   = '0;
    m[127-8*idx -: 8] = f.bitx[3] ? 8'hff : (8'h01 << f.bitx[2:0]);
    for (int rd = 0; rd <= 10; rd++) begin
      hit = f.en && (rd == int'(f.rnd) ||
                     (f.mode && rd >= int'(f.rnd) && rd <= int'(f.stop)));
      if (rd == 0) begin
        kp = k; kq = k; p = pt; q = pt;
      end else begin
        kp = key_step(kp, rc);
        kq = key_step(kq, rc);
        rc = gmul(rc, 8'h02);
        p = sub_all(p); q = sub_all(q);
        if (hit && f.func == 4'd0) begin p ^= m; res.err = 1'b1; end
        p = shift(p); q = shift(q);
        if (hit && f.func == 4'd1) begin p ^= m; res.err = 1'b1; end
        if (rd < 10) begin
          p = mix(p); q = mix(q);
          if (hit && f.func == 4'd2) begin p ^= m; res.err = 1'b1; end
        end
      end
      if (hit && f.func == 4'd4) begin kp ^= m; res.err = 1'b1; end
      p = p ^ kp;
      q = q ^ kq;
      if (hit && f.func == 4'd3) begin p ^= m; res.err = 1'b1; end
      if (!res.det && p != q) begin res.det = 1'b1; res.loc = 4'(rd); end
    end
    res.ct = p;
    return res;
  endfunction

  // ---------------- helpers ----------------
  function automatic st_t to_state(input logic [127:0] v);
    st_t s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = gb(v, r + 4*c);
    return s;
  endfunction

  function automatic logic [127:0] from_state(input st_t s);
    logic [127:0] v;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) v[127-8*(r+4*c) -: 8] = s[r][c];
    return v;
  endfunction

  function automatic fi_t mk_fi(input int en, input int mode, input int func, input int rnd,
                                input int stop, input int row, input int col, input int bitx);
    fi_t f;
    f.en = 1'(en); f.mode = 1'(mode); f.func = 4'(func); f.rnd = 4'(rnd);
    f.stop = 4'(stop); f.row = 2'(row); f.col = 2'(col); f.bitx = 4'(bitx);
    return f;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp,
                     input logic want_eq);
    n_cmp++;
    if ((act === exp) != want_eq) begin
      n_bad++;
      $display("FAIL %s: got %h, required %s%h", name, act, want_eq ? "" : "anything but ", exp);
    end
  endtask

  task automatic drive(input logic [127:0] pt, input logic [127:0] k, input fi_t f);
    data = to_state(pt); key = to_state(k);
    en_FI = f.en; mode_FI = f.mode; func_FI = f.func; round_FI = f.rnd;
    round_stop_FI = f.stop; row_FI = f.row; column_FI = f.col; bit_index_FI = f.bitx;
  endtask

  task automatic start_enc(input logic [127:0] pt, input logic [127:0] k, input fi_t f);
    @(negedge clock);
    reset = 1'b1;
    drive(pt, k, f);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Releases reset, samples done after clock 10 and clock 11, returns the ciphertext.
  task automatic run_enc(input logic [127:0] pt, input logic [127:0] k, input fi_t f,
                         output logic [127:0] ct, output logic d10, output logic d11);
    start_enc(pt, k, f);
    repeat (10) @(posedge clock);
    #1 d10 = done;
    @(posedge clock);
    #1 d11 = done;
    ct = from_state(ciphertext);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    vec_t         vecs[12];
    fi_t          none, f;
    res_t         m;
    logic [127:0] ct, k, pt;
    logic         d10, d11;

    build_sbox();
    none = '0;
    drive(P1, K1, none);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ct", from_state(ciphertext), 128'd0, 1'b1);
    chk("reset_flags", 128'({done, error_FI, fault_detected, fault_location}), 128'd0, 1'b1);

    vecs[0]  = '{K1, P1, none,                          CT1, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{K2, P2, none,                          CT2, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[2]  = '{K1, P1, mk_fi(1, 0, 0, 5, 0, 1, 2, 3),   CT1, 1'b0, 1'b1, 1'b1, 4'd5};
    vecs[3]  = '{K1, P1, mk_fi(1, 1, 3, 2, 4, 0, 0, 8),   CT1, 1'b0, 1'b1, 1'b1, 4'd2};
    vecs[4]  = '{K1, P1, mk_fi(1, 0, 2, 10, 0, 2, 3, 0),  CT1, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[5]  = '{K1, P1, mk_fi(1, 0, 4, 0, 0, 3, 1, 0),   CT1, 1'b0, 1'b1, 1'b1, 4'd0};
    vecs[6]  = '{K1, P1, mk_fi(1, 0, 0, 0, 0, 0, 0, 7),   CT1, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[7]  = '{K1, P1, mk_fi(1, 1, 1, 7, 3, 2, 2, 15),  CT1, 1'b0, 1'b1, 1'b1, 4'd7};
    vecs[8]  = '{K1, P1, mk_fi(1, 0, 3, 10, 0, 3, 3, 15), CT1, 1'b0, 1'b1, 1'b1, 4'd10};
    vecs[9]  = '{K2, P2, mk_fi(0, 1, 3, 1, 9, 1, 1, 1),   CT2, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[10] = '{K1, P1, mk_fi(1, 0, 5, 3, 0, 0, 0, 0),   CT1, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[11] = '{K2, P2, mk_fi(1, 0, 2, 9, 0, 0, 1, 4),   CT2, 1'b0, 1'b1, 1'b1, 4'd9};

    for (int i = 0; i < 12; i++) begin
      m = ref_aes(vecs[i].pt, vecs[i].k, vecs[i].f);
      run_enc(vecs[i].pt, vecs[i].k, vecs[i].f, ct, d10, d11);
      chk($sformatf("vec%0d_ct", i), ct, vecs[i].ct, vecs[i].ct_eq);
      chk($sformatf("vec%0d_ct_model", i), ct, m.ct, 1'b1);
      chk($sformatf("vec%0d_done_clk10", i), 128'(d10), 128'd0, 1'b1);
      chk($sformatf("vec%0d_done_clk11", i), 128'(d11), 128'd1, 1'b1);
      chk($sformatf("vec%0d_flags", i), 128'({error_FI, fault_detected, fault_location}),
          128'({vecs[i].err, vecs[i].det, vecs[i].loc}), 1'b1);
      if (i == 0) begin
        repeat (5) @(posedge clock);
        #1;
        chk("hold_ct", from_state(ciphertext), CT1, 1'b1);
        chk("hold_done", 128'(done), 128'd1, 1'b1);
      end
    end

    // Abort a faulted run at clock 6, then rerun clean.
    start_enc(P1, K1, mk_fi(1, 0, 3, 2, 0, 1, 1, 9));
    repeat (6) @(posedge clock);
    #1;
    chk("abort_pre_flags", 128'({done, error_FI, fault_detected, fault_location}),
        128'({1'b0, 1'b1, 1'b1, 4'd2}), 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_ct", from_state(ciphertext), 128'd0, 1'b1);
    chk("abort_flags", 128'({done, error_FI, fault_detected, fault_location}), 128'd0, 1'b1);
    run_enc(P1, K1, none, ct, d10, d11);
    chk("rerun_ct", ct, CT1, 1'b1);
    chk("rerun_done", 128'({d10, d11}), 128'b01, 1'b1);
    chk("rerun_flags", 128'({error_FI, fault_detected, fault_location}), 128'd0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      f  = mk_fi(int'($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 6),
                 $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 15));
      m = ref_aes(pt, k, f);
      exp_q.push_back(m.ct);
      exp_q.push_back(128'({1'b1, m.err, m.det, m.loc}));
      run_enc(pt, k, f, ct, d10, d11);
      chk($sformatf("rand%0d_ct", i), ct, exp_q.pop_front(), 1'b1);
      chk($sformatf("rand%0d_flags", i),
          128'({d11, error_FI, fault_detected, fault_location}), exp_q.pop_front(), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
